// File: rtl/cam_pkg.sv
// Types shared between the CAM request front-end and the CAM itself.
package cam_pkg;

  localparam int unsigned KEY_W = 32;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } COMMAND;

  typedef enum logic {
    LOOKUP = 1'b0,
    INSERT = 1'b1
  } REQ_OP;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cam_alloc_ctrl.sv
// CAM request front-end: serialises LOOKUP/INSERT requests into CAM READ/WRITE cycles
// and allocates INSERT targets by filling free entries in order, then FIFO eviction.
module cam_alloc_ctrl
  import cam_pkg::*;
#(
  parameter  int unsigned SIZE  = 8,
  localparam int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  REQ_OP            req_op,
  input  logic [KEY_W-1:0] req_data,
  output logic             cam_enable,
  output COMMAND           cam_command,
  output logic [KEY_W-1:0] cam_data,
  output logic [IDX_W-1:0] cam_write_idx,
  input  logic [IDX_W-1:0] cam_read_idx,
  input  logic             cam_hit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_idx,
  output logic             rsp_evict
);

  localparam int unsigned CNT_W = IDX_W + 1;

  state_e           state_q, state_d;
  REQ_OP            op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             cam_enable_q, cam_enable_d;
  COMMAND           cam_command_q, cam_command_d;
  logic [KEY_W-1:0] cam_data_q, cam_data_d;
  logic [IDX_W-1:0] cam_write_idx_q, cam_write_idx_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic             rsp_evict_q, rsp_evict_d;

  // State, allocation bookkeeping and registered CAM/response drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      op_q            <= LOOKUP;
      key_q           <= '0;
      alloc_ptr_q     <= '0;
      fill_cnt_q      <= '0;
      cam_enable_q    <= 1'b0;
      cam_command_q   <= READ;
      cam_data_q      <= '0;
      cam_write_idx_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_idx_q       <= '0;
      rsp_evict_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      key_q           <= key_d;
      alloc_ptr_q     <= alloc_ptr_d;
      fill_cnt_q      <= fill_cnt_d;
      cam_enable_q    <= cam_enable_d;
      cam_command_q   <= cam_command_d;
      cam_data_q      <= cam_data_d;
      cam_write_idx_q <= cam_write_idx_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_idx_q       <= rsp_idx_d;
      rsp_evict_q     <= rsp_evict_d;
    end
  end

  // CAM drive is decoded from the next state so it lines up with the LOOKUP/WRITE cycles.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    key_d           = key_q;
    alloc_ptr_d     = alloc_ptr_q;
    fill_cnt_d      = fill_cnt_q;
    cam_enable_d    = 1'b0;
    cam_command_d   = READ;
    cam_data_d      = cam_data_q;
    cam_write_idx_d = cam_write_idx_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_hit_d       = rsp_hit_q;
    rsp_idx_d       = rsp_idx_q;
    rsp_evict_d     = rsp_evict_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d          = req_op;
          key_d         = req_data;
          state_d       = ST_LOOKUP;
          cam_enable_d  = 1'b1;
          cam_command_d = READ;
          cam_data_d    = req_data;
        end
      end
      ST_LOOKUP: begin
        if (cam_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_idx_d   = cam_read_idx;
          rsp_evict_d = 1'b0;
        end else if (op_q == LOOKUP) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_idx_d   = '0;
          rsp_evict_d = 1'b0;
        end else begin
          state_d         = ST_WRITE;
          cam_enable_d    = 1'b1;
          cam_command_d   = WRITE;
          cam_data_d      = key_q;
          cam_write_idx_d = alloc_ptr_q;
          rsp_hit_d       = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_idx_d   = alloc_ptr_q;
        rsp_evict_d = (fill_cnt_q == CNT_W'(SIZE));
        alloc_ptr_d = (alloc_ptr_q == IDX_W'(SIZE - 1)) ? '0 : alloc_ptr_q + IDX_W'(1);
        if (fill_cnt_q != CNT_W'(SIZE)) begin
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates handshake and CAM enable so nothing is accepted or written in a reset cycle.
  assign req_ready     = (state_q == ST_IDLE) && !reset;
  assign cam_enable    = cam_enable_q && !reset;
  assign cam_command   = cam_command_q;
  assign cam_data      = cam_data_q;
  assign cam_write_idx = cam_write_idx_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_idx       = rsp_idx_q;
  assign rsp_evict     = rsp_evict_q;

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Bench: SIZE=8 and SIZE=5 controllers driven in lockstep, each with a behavioural CAM.
module tb_cam_alloc_ctrl;
  import cam_pkg::*;

  localparam int unsigned S8 = 8;
  localparam int unsigned S5 = 5;
  localparam int unsigned W8 = $clog2(S8);
  localparam int unsigned W5 = $clog2(S5);
  localparam int NVEC    = 25;
  localparam int HOLD_I  = 20;
  localparam int RESET_I = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  REQ_OP       req_op;
  logic [31:0] req_data;
  logic        rsp_ready;

  logic rr8, en8, hit8, rv8, rh8, re8;
  COMMAND cmd8;
  logic [31:0] cd8;
  logic [W8-1:0] wi8, ri8, rx8;
  logic rr5, en5, hit5, rv5, rh5, re5;
  COMMAND cmd5;
  logic [31:0] cd5;
  logic [W5-1:0] wi5, ri5, rx5;

  cam_alloc_ctrl #(.SIZE(S8)) u8 (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(rr8), .req_op(req_op),
    .req_data(req_data), .cam_enable(en8), .cam_command(cmd8), .cam_data(cd8),
    .cam_write_idx(wi8), .cam_read_idx(ri8), .cam_hit(hit8), .rsp_valid(rv8),
    .rsp_ready(rsp_ready), .rsp_hit(rh8), .rsp_idx(rx8), .rsp_evict(re8)
  );

  cam_alloc_ctrl #(.SIZE(S5)) u5 (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(rr5), .req_op(req_op),
    .req_data(req_data), .cam_enable(en5), .cam_command(cmd5), .cam_data(cd5),
    .cam_write_idx(wi5), .cam_read_idx(ri5), .cam_hit(hit5), .rsp_valid(rv5),
    .rsp_ready(rsp_ready), .rsp_hit(rh5), .rsp_idx(rx5), .rsp_evict(re5)
  );

  // Behavioural CAMs: combinational hit on READ, lowest matching index wins, reset clears.
  logic [31:0] k8 [S8];
  logic [S8-1:0] v8 = '0;
  logic [31:0] k5 [S5];
  logic [S5-1:0] v5 = '0;
  int wr8 = 0;
  int wr5 = 0;

  always_comb begin
    hit8 = 1'b0;
    ri8  = '0;
    if (en8 && cmd8 == READ)
      for (int i = S8 - 1; i >= 0; i--)
        if (v8[i] && k8[i] == cd8) begin hit8 = 1'b1; ri8 = W8'(i); end
  end

  always_comb begin
    hit5 = 1'b0;
    ri5  = '0;
    if (en5 && cmd5 == READ)
      for (int i = S5 - 1; i >= 0; i--)
        if (v5[i] && k5[i] == cd5) begin hit5 = 1'b1; ri5 = W5'(i); end
  end

  always @(posedge clk) begin
    if (en8 && cmd8 == WRITE) wr8 <= wr8 + 1;
    if (en5 && cmd5 == WRITE) wr5 <= wr5 + 1;
    if (rst) begin
      v8 <= '0;
      v5 <= '0;
    end else begin
      if (en8 && cmd8 == WRITE) begin k8[wi8] <= cd8; v8[wi8] <= 1'b1; end
      if (en5 && cmd5 == WRITE) begin k5[wi5] <= cd5; v5[wi5] <= 1'b1; end
    end
  end

  typedef struct {
    logic hit;
    int   idx;
    logic evict;
  } rsp_t;

  typedef struct {
    REQ_OP       op;
    logic [31:0] data;
    logic        h8;
    int          i8;
    logic        e8;
    logic        h5;
    int          i5;
    logic        e5;
  } vec_t;

  vec_t tbl [NVEC];
  rsp_t q8 [$];
  rsp_t q5 [$];
  rsp_t m8, m5;
  int n_cmp  = 0;
  int n_miss = 0;
  int cur_vec = -1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL v%0d %s: got %0d, expected %0d", cur_vec, name, act, exp);
    end
  endtask

  // Scoreboard pop: a response is consumed on the edge following a valid&&ready sample.
  always @(negedge clk) begin
    if (!rst && rv8 && rsp_ready) begin
      if (q8.size() == 0) check("rsp8_unexpected", 1, 0);
      else begin
        m8 = q8.pop_front();
        check("rsp8_hit", int'(rh8), int'(m8.hit));
        check("rsp8_idx", int'(rx8), m8.idx);
        check("rsp8_evict", int'(re8), int'(m8.evict));
      end
    end
    if (!rst && rv5 && rsp_ready) begin
      if (q5.size() == 0) check("rsp5_unexpected", 1, 0);
      else begin
        m5 = q5.pop_front();
        check("rsp5_hit", int'(rh5), int'(m5.hit));
        check("rsp5_idx", int'(rx5), m5.idx);
        check("rsp5_evict", int'(re5), int'(m5.evict));
      end
    end
  end

  task automatic do_req(input vec_t v, input int hold);
    int lat8, lat5, w8s, w5s;
    @(negedge clk);
    check("req_ready8", int'(rr8), 1);
    check("req_ready5", int'(rr5), 1);
    if (hold > 0) rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = v.op;
    req_data  = v.data;
    q8.push_back('{v.h8, v.i8, v.e8});
    q5.push_back('{v.h5, v.i5, v.e5});
    w8s = wr8;
    w5s = wr5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = REQ_OP'($urandom_range(0, 1));
    req_data  = $urandom;
    lat8 = 0;
    lat5 = 0;
    for (int c = 1; c <= 10 && (lat8 == 0 || lat5 == 0); c++) begin
      if (lat8 == 0 && rv8) lat8 = c;
      if (lat5 == 0 && rv5) lat5 = c;
      if (lat8 == 0 || lat5 == 0) begin @(posedge clk); #1; end
    end
    check("latency8", lat8, (v.op == INSERT && !v.h8) ? 3 : 2);
    check("latency5", lat5, (v.op == INSERT && !v.h5) ? 3 : 2);
    for (int k = 0; k < hold; k++) begin
      check("hold_valid8", int'(rv8), 1);
      check("hold_hit8", int'(rh8), int'(v.h8));
      check("hold_idx8", int'(rx8), v.i8);
      check("hold_rdy8", int'(rr8), 0);
      check("hold_en8", int'(en8), 0);
      check("hold_valid5", int'(rv5), 1);
      check("hold_idx5", int'(rx5), v.i5);
      check("hold_en5", int'(en5), 0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle8", int'(rr8), 1);
    check("idle5", int'(rr5), 1);
    check("writes8", wr8 - w8s, (v.op == INSERT && !v.h8) ? 1 : 0);
    check("writes5", wr5 - w5s, (v.op == INSERT && !v.h5) ? 1 : 0);
    check("sb_empty", q8.size() + q5.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w8s, w5s;
    //            op      key           h8  i8 e8   h5  i5 e5
    tbl[0]  = '{LOOKUP, 32'hDEADBEEF, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
    tbl[1]  = '{INSERT, 32'h11,       1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
    tbl[2]  = '{INSERT, 32'h22,       1'b0, 1, 1'b0, 1'b0, 1, 1'b0};
    tbl[3]  = '{INSERT, 32'h33,       1'b0, 2, 1'b0, 1'b0, 2, 1'b0};
    tbl[4]  = '{LOOKUP, 32'h22,       1'b1, 1, 1'b0, 1'b1, 1, 1'b0};
    tbl[5]  = '{INSERT, 32'h22,       1'b1, 1, 1'b0, 1'b1, 1, 1'b0};
    tbl[6]  = '{INSERT, 32'h44,       1'b0, 3, 1'b0, 1'b0, 3, 1'b0};
    tbl[7]  = '{INSERT, 32'h55,       1'b0, 4, 1'b0, 1'b0, 4, 1'b0};
    tbl[8]  = '{INSERT, 32'h66,       1'b0, 5, 1'b0, 1'b0, 0, 1'b1};
    tbl[9]  = '{LOOKUP, 32'h11,       1'b1, 0, 1'b0, 1'b0, 0, 1'b0};
    tbl[10] = '{INSERT, 32'h77,       1'b0, 6, 1'b0, 1'b0, 1, 1'b1};
    tbl[11] = '{INSERT, 32'h88,       1'b0, 7, 1'b0, 1'b0, 2, 1'b1};
    tbl[12] = '{INSERT, 32'h99,       1'b0, 0, 1'b1, 1'b0, 3, 1'b1};
    tbl[13] = '{LOOKUP, 32'h11,       1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
    tbl[14] = '{LOOKUP, 32'h99,       1'b1, 0, 1'b0, 1'b1, 3, 1'b0};
    tbl[15] = '{INSERT, 32'h22,       1'b1, 1, 1'b0, 1'b0, 4, 1'b1};
    tbl[16] = '{LOOKUP, 32'h55,       1'b1, 4, 1'b0, 1'b0, 0, 1'b0};
    tbl[17] = '{LOOKUP, 32'h66,       1'b1, 5, 1'b0, 1'b1, 0, 1'b0};
    tbl[18] = '{INSERT, 32'hAA,       1'b0, 1, 1'b1, 1'b0, 0, 1'b1};
    tbl[19] = '{LOOKUP, 32'h22,       1'b0, 0, 1'b0, 1'b1, 4, 1'b0};
    tbl[20] = '{LOOKUP, 32'h77,       1'b1, 6, 1'b0, 1'b1, 1, 1'b0};
    tbl[21] = '{LOOKUP, 32'hBB,       1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
    tbl[22] = '{INSERT, 32'hCC,       1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
    tbl[23] = '{INSERT, 32'hBB,       1'b0, 1, 1'b0, 1'b0, 1, 1'b0};
    tbl[24] = '{LOOKUP, 32'hCC,       1'b1, 0, 1'b0, 1'b1, 0, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = LOOKUP;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready8", int'(rr8), 0);
    check("rst_cam_en8", int'(en8), 0);
    check("rst_rsp_valid8", int'(rv8), 0);
    check("rst_req_ready5", int'(rr5), 0);
    rst = 1'b0;
    #1;
    check("rst_cmd8", int'(cmd8), int'(READ));
    check("rst_cam_data8", int'(cd8), 0);
    check("rst_wr_idx8", int'(wi8), 0);
    check("rst_rsp_hit8", int'(rh8), 0);
    check("rst_rsp_idx8", int'(rx8), 0);
    check("rst_rsp_evict8", int'(re8), 0);
    check("post_rst_ready8", int'(rr8), 1);

    for (int i = 0; i < NVEC; i++) begin
      if (i == RESET_I) begin
        // Abandon an INSERT miss while it sits in its WRITE cycle.
        cur_vec = -2;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = INSERT;
        req_data  = 32'hBB;
        w8s = wr8;
        w5s = wr5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wr_state_en8", int'(en8), 1);
        check("wr_state_cmd8", int'(cmd8), int'(WRITE));
        rst = 1'b1;
        #1;
        check("rst_mid_en8", int'(en8), 0);
        check("rst_mid_ready8", int'(rr8), 0);
        check("rst_mid_en5", int'(en5), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_drop_valid8", int'(rv8), 0);
        check("rst_drop_valid5", int'(rv5), 0);
        check("rst_ready8", int'(rr8), 1);
        check("rst_ready5", int'(rr5), 1);
        check("rst_no_write8", wr8 - w8s, 0);
        check("rst_no_write5", wr5 - w5s, 0);
      end
      cur_vec = i;
      do_req(tbl[i], (i == HOLD_I) ? 4 : 0);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
